// File: rtl/cfg_pkg.sv
// Shared types and constants for the serial configuration loader.
package cfg_pkg;

    localparam int N_TILES   = 8;
    localparam int TILE_BITS = 33;
    localparam int N_SB      = 5;
    localparam int SB_BITS   = 16;
    localparam int ADDR_W    = 4;
    localparam int CRC_BITS  = 8;

    localparam logic [15:0]       SYNC_WORD = 16'hA5C3;
    localparam logic [7:0]        CRC_POLY  = 8'h07;
    localparam logic [ADDR_W-1:0] LT_BASE   = 4'd0;
    localparam logic [ADDR_W-1:0] SB_BASE   = 4'd8;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        LOAD_LT = 3'd1,
        LOAD_SB = 3'd2,
        CHECK   = 3'd3,
        DONE    = 3'd4,
        ERROR   = 3'd5
    } state_t;

endpackage

// File: rtl/cfg_loader_if.sv
// Bitstream input and frame-write output bundle of the configuration loader.
//
// Handshake: a bit on cfg_din is transferred in exactly those cycles where
// cfg_valid && cfg_ready are both high at the rising clock edge; the source
// may hold or drop cfg_valid freely, and a low cycle simply stalls the loader.
// frame_we is a one-cycle strobe qualifying frame_addr/frame_data; there is no
// back-pressure on the frame write side.
interface cfg_loader_if;
    import cfg_pkg::*;

    logic                  cfg_din;
    logic                  cfg_valid;
    logic                  cfg_clear;
    logic                  cfg_ready;
    logic [TILE_BITS-1:0]  frame_data;
    logic [ADDR_W-1:0]     frame_addr;
    logic                  frame_we;
    logic                  cfg_done;
    logic                  cfg_error;
    logic                  fabric_en;

    // Bitstream source side (drives bits, observes results).
    modport master (
        output cfg_din, cfg_valid, cfg_clear,
        input  cfg_ready, frame_data, frame_addr, frame_we,
               cfg_done, cfg_error, fabric_en
    );

    // Loader side.
    modport slave (
        input  cfg_din, cfg_valid, cfg_clear,
        output cfg_ready, frame_data, frame_addr, frame_we,
               cfg_done, cfg_error, fabric_en
    );

endinterface

// File: rtl/cfg_crc8.sv
// Bit-serial CRC-8 (poly 0x07, init 0x00); clear has priority over enable.
module cfg_crc8
    import cfg_pkg::*;
(
    input  logic       clock,
    input  logic       clear,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);

    logic fb;
    assign fb = crc[7] ^ din;

    // Shift one payload bit through the LFSR when enabled.
    always_ff @(posedge clock) begin
        if (clear) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
        end
    end

endmodule

// File: rtl/cfg_loader.sv
// Serial configuration loader: sync hunt, tile/switch-box frame deserialise
// and write, trailing CRC check gating the fabric enable.
module cfg_loader
    import cfg_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    cfg_loader_if.slave  bus,
    output state_t       state_dbg
);

    state_t                state;
    logic [TILE_BITS-2:0]  shreg;
    logic [5:0]            bit_cnt;
    logic [ADDR_W-1:0]     idx;
    logic [7:0]            crc;

    logic                  ready_q;
    logic [TILE_BITS-1:0]  frame_data_q;
    logic [ADDR_W-1:0]     frame_addr_q;
    logic                  frame_we_q;
    logic                  done_q;
    logic                  error_q;

    logic                  accept;
    logic [TILE_BITS-1:0]  shifted;
    logic                  sync_hit;
    logic                  crc_en;

    assign accept   = bus.cfg_valid && ready_q;
    // Shift register content as it will be after taking the current bit.
    assign shifted  = {shreg, bus.cfg_din};
    assign sync_hit = accept && (state == HUNT) && (shifted[15:0] == SYNC_WORD);
    assign crc_en   = accept && ((state == LOAD_LT) || (state == LOAD_SB));

    cfg_crc8 u_crc (
        .clock (clock),
        .clear (reset || sync_hit),
        .en    (crc_en),
        .din   (bus.cfg_din),
        .crc   (crc)
    );

    // Loader FSM with registered outputs; completed words are written the
    // cycle after their last bit while the shifter already restarts empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= HUNT;
            shreg        <= '0;
            bit_cnt      <= '0;
            idx          <= '0;
            ready_q      <= 1'b0;
            frame_data_q <= '0;
            frame_addr_q <= '0;
            frame_we_q   <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            frame_we_q <= 1'b0;
            case (state)
                HUNT: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        if (sync_hit) begin
                            state   <= LOAD_LT;
                            shreg   <= '0;
                            bit_cnt <= '0;
                            idx     <= '0;
                        end else begin
                            shreg <= shifted[TILE_BITS-2:0];
                        end
                    end
                end
                LOAD_LT: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        if (bit_cnt == 6'(TILE_BITS - 1)) begin
                            frame_we_q   <= 1'b1;
                            frame_addr_q <= LT_BASE + idx;
                            frame_data_q <= shifted;
                            shreg        <= '0;
                            bit_cnt      <= '0;
                            if (idx == 4'(N_TILES - 1)) begin
                                idx   <= '0;
                                state <= LOAD_SB;
                            end else begin
                                idx <= idx + 4'd1;
                            end
                        end else begin
                            shreg   <= shifted[TILE_BITS-2:0];
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                end
                LOAD_SB: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        if (bit_cnt == 6'(SB_BITS - 1)) begin
                            frame_we_q   <= 1'b1;
                            frame_addr_q <= SB_BASE + idx;
                            frame_data_q <= {{(TILE_BITS-SB_BITS){1'b0}}, shifted[SB_BITS-1:0]};
                            shreg        <= '0;
                            bit_cnt      <= '0;
                            if (idx == 4'(N_SB - 1)) begin
                                idx   <= '0;
                                state <= CHECK;
                            end else begin
                                idx <= idx + 4'd1;
                            end
                        end else begin
                            shreg   <= shifted[TILE_BITS-2:0];
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                end
                CHECK: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        if (bit_cnt == 6'(CRC_BITS - 1)) begin
                            shreg   <= '0;
                            bit_cnt <= '0;
                            ready_q <= 1'b0;
                            if (shifted[7:0] == crc) begin
                                state  <= DONE;
                                done_q <= 1'b1;
                            end else begin
                                state   <= ERROR;
                                error_q <= 1'b1;
                            end
                        end else begin
                            shreg   <= shifted[TILE_BITS-2:0];
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                end
                DONE, ERROR: begin
                    ready_q <= 1'b0;
                    if (bus.cfg_clear) begin
                        state   <= HUNT;
                        ready_q <= 1'b1;
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= HUNT;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cfg_ready  = ready_q;
    assign bus.frame_data = frame_data_q;
    assign bus.frame_addr = frame_addr_q;
    assign bus.frame_we   = frame_we_q;
    assign bus.cfg_done   = done_q;
    assign bus.cfg_error  = error_q;
    assign bus.fabric_en  = done_q;
    assign state_dbg      = state;

endmodule

// File: tb/tb_cfg_loader.sv
// Directed bench for cfg_loader: scoreboarded frame writes plus status checks.
module tb_cfg_loader;
    import cfg_pkg::*;

    // ---------------- clock / reset ----------------
    logic clock;
    logic reset;
    state_t state_dbg;

    cfg_loader_if bus ();

    cfg_loader dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    int we_count = 0;
    bit gap_mode = 1'b0;
    logic [36:0] exp_q[$];          // {addr[3:0], data[32:0]}
    logic [32:0] tile_v[N_TILES];
    logic [15:0] sb_v[N_SB];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame write monitor, sampled away from the active edge.
    always @(negedge clock) begin
        if (bus.frame_we === 1'b1) begin
            logic [36:0] e;
            we_count++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL unexpected_we observed addr=%0h data=%0h expected no write",
                       bus.frame_addr, bus.frame_data);
            end else begin
                e = exp_q.pop_front();
                check("we_addr", 64'(bus.frame_addr), 64'(e[36:33]));
                check("we_data", 64'(bus.frame_data), 64'(e[32:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_bit(input logic b);
        if (gap_mode) begin
            bus.cfg_valid = 1'b0;
            @(posedge clock);
            #1;
        end
        bus.cfg_din   = b;
        bus.cfg_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.cfg_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [32:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    function automatic logic [7:0] payload_crc();
        logic [7:0] c;
        c = 8'h00;
        for (int t = 0; t < N_TILES; t++)
            for (int i = TILE_BITS - 1; i >= 0; i--) c = crc_step(c, tile_v[t][i]);
        for (int s = 0; s < N_SB; s++)
            for (int i = SB_BITS - 1; i >= 0; i--) c = crc_step(c, sb_v[s][i]);
        return c;
    endfunction

    task automatic clear_payload();
        for (int t = 0; t < N_TILES; t++) tile_v[t] = '0;
        for (int s = 0; s < N_SB; s++) sb_v[s] = '0;
    endtask

    // Sync + full payload + CRC (xor'd with crc_xor); writes go to the scoreboard.
    task automatic send_stream(input logic [7:0] crc_xor, input bit clear_in_sb);
        logic [7:0] c;
        c = payload_crc() ^ crc_xor;
        we_count = 0;
        for (int t = 0; t < N_TILES; t++) exp_q.push_back({4'(t), tile_v[t]});
        for (int s = 0; s < N_SB; s++) exp_q.push_back({4'(8 + s), 17'b0, sb_v[s]});
        send_bits(33'(16'hA5C3), 16);
        for (int t = 0; t < N_TILES; t++) send_bits(tile_v[t], TILE_BITS);
        if (clear_in_sb) bus.cfg_clear = 1'b1;
        for (int s = 0; s < N_SB; s++) send_bits(33'(sb_v[s]), SB_BITS);
        bus.cfg_clear = 1'b0;
        send_bits(33'(c), 8);
    endtask

    task automatic pulse_clear();
        bus.cfg_clear = 1'b1;
        @(posedge clock);
        #1;
        bus.cfg_clear = 1'b0;
    endtask

    task automatic check_done(input string tag);
        check({tag, "_done"},  64'(bus.cfg_done),  64'd1);
        check({tag, "_fen"},   64'(bus.fabric_en), 64'd1);
        check({tag, "_err"},   64'(bus.cfg_error), 64'd0);
        check({tag, "_ready"}, 64'(bus.cfg_ready), 64'd0);
        check({tag, "_state"}, 64'(state_dbg),     64'(DONE));
        check({tag, "_wecnt"}, 64'(we_count),      64'd13);
        check({tag, "_qempty"}, 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset         = 1'b1;
        bus.cfg_din   = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_clear = 1'b0;
        idle(3);

        // Reset state
        check("rst_ready", 64'(bus.cfg_ready),  64'd0);
        check("rst_done",  64'(bus.cfg_done),   64'd0);
        check("rst_err",   64'(bus.cfg_error),  64'd0);
        check("rst_fen",   64'(bus.fabric_en),  64'd0);
        check("rst_we",    64'(bus.frame_we),   64'd0);
        check("rst_addr",  64'(bus.frame_addr), 64'd0);
        check("rst_data",  64'(bus.frame_data), 64'd0);
        check("rst_state", 64'(state_dbg),      64'(HUNT));
        reset = 1'b0;
        idle(2);
        check("hunt_ready", 64'(bus.cfg_ready), 64'd1);

        // All-zero load
        clear_payload();
        send_stream(8'h00, 1'b0);
        idle(1);
        check_done("zero");

        // Bits offered while DONE are ignored
        send_bits(33'h0FF, 8);
        check("done_ignore_state", 64'(state_dbg), 64'(DONE));
        check("done_ignore_we",    64'(we_count),  64'd13);
        pulse_clear();
        check("clr1_state", 64'(state_dbg),    64'(HUNT));
        check("clr1_done",  64'(bus.cfg_done), 64'd0);
        check("clr1_fen",   64'(bus.fabric_en), 64'd0);
        check("clr1_ready", 64'(bus.cfg_ready), 64'd1);

        // Garbage + partial sync, then true sync, tile0 = 33'h1_0000_8001
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
        send_bits(33'h0A5, 8);
        clear_payload();
        tile_v[0] = 33'h1_0000_8001;
        send_stream(8'h00, 1'b0);
        idle(1);
        check_done("tile0");
        pulse_clear();

        // Same stream with valid low every other cycle
        gap_mode = 1'b1;
        send_stream(8'h00, 1'b0);
        gap_mode = 1'b0;
        idle(1);
        check_done("gap");
        pulse_clear();

        // Mixed payload with the last CRC bit flipped
        clear_payload();
        tile_v[2] = 33'h0_DEAD_BEEF;
        tile_v[7] = 33'h1_2345_6789;
        sb_v[0]   = 16'h8001;
        sb_v[4]   = 16'hFFFF;
        send_stream(8'h01, 1'b0);
        idle(1);
        check("bad_err",   64'(bus.cfg_error), 64'd1);
        check("bad_done",  64'(bus.cfg_done),  64'd0);
        check("bad_fen",   64'(bus.fabric_en), 64'd0);
        check("bad_ready", 64'(bus.cfg_ready), 64'd0);
        check("bad_state", 64'(state_dbg),     64'(ERROR));
        check("bad_wecnt", 64'(we_count),      64'd13);
        pulse_clear();
        check("clr2_state", 64'(state_dbg),     64'(HUNT));
        check("clr2_err",   64'(bus.cfg_error), 64'd0);
        check("clr2_ready", 64'(bus.cfg_ready), 64'd1);

        // Abort after 100 payload bits: frames 0..2 written, frame 3 never
        clear_payload();
        tile_v[0] = 33'h1_1111_1111;
        tile_v[1] = 33'h0_2222_2222;
        tile_v[2] = 33'h1_3333_3333;
        tile_v[3] = 33'h1_4444_4444;
        we_count = 0;
        for (int t = 0; t < 3; t++) exp_q.push_back({4'(t), tile_v[t]});
        send_bits(33'(16'hA5C3), 16);
        for (int t = 0; t < 3; t++) send_bits(tile_v[t], TILE_BITS);
        send_bit(tile_v[3][32]);
        reset = 1'b1;
        idle(1);
        check("abort_state", 64'(state_dbg),     64'(HUNT));
        check("abort_ready", 64'(bus.cfg_ready), 64'd0);
        reset = 1'b0;
        idle(3);
        check("abort_wecnt",  64'(we_count),      64'd3);
        check("abort_qempty", 64'(exp_q.size()),  64'd0);
        tile_v[3] = 33'h0_5555_AAAA;
        sb_v[2]   = 16'h1234;
        send_stream(8'h00, 1'b0);
        idle(1);
        check_done("reload");
        pulse_clear();

        // cfg_clear held during LOAD_SB has no effect
        clear_payload();
        tile_v[5] = 33'h0_0F0F_0F0F;
        sb_v[1]   = 16'hC3A5;
        sb_v[3]   = 16'h0001;
        send_stream(8'h00, 1'b1);
        idle(1);
        check_done("clrsb");

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
